// File: rtl/collision_scorer.sv
// rtl/collision_scorer.sv - laser/alien overlap detection, cell decode, BCD score and lives
// Decodes the struck formation cell by repeated subtraction and commits at most one kill per frame.
module collision_scorer #(
  parameter int NUM_ROWS    = 3,
  parameter int NUM_COLUMNS = 5,
  parameter int CELL_W      = 32,
  parameter int CELL_H      = 24,
  parameter int START_LIVES = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [9:0]                      hpos,
  input  logic [9:0]                      vpos,
  input  logic                            display_on,
  input  logic                            vsync,
  input  logic                            laser_gfx,
  input  logic                            alien_pixel,
  input  logic [9:0]                      formation_x,
  input  logic [9:0]                      formation_y,
  input  logic [NUM_ROWS*NUM_COLUMNS-1:0] alive_matrix,
  input  logic                            bomb_hit,
  output logic                            kill_valid,
  output logic [1:0]                      kill_row,
  output logic [2:0]                      kill_col,
  output logic                            hit_alien,
  output logic [7:0]                      score,
  output logic [1:0]                      lives,
  output logic                            game_over,
  output logic                            wave_clear
);

  localparam logic [2:0] LP_COLS  = 3'(NUM_COLUMNS);
  localparam logic [2:0] LP_ROWS  = 3'(NUM_ROWS);
  localparam logic [4:0] LP_COLS5 = 5'(NUM_COLUMNS);
  localparam logic [9:0] LP_CW    = 10'(CELL_W);
  localparam logic [9:0] LP_CH    = 10'(CELL_H);
  localparam logic [1:0] LP_LIVES = 2'(START_LIVES);

  typedef enum logic [1:0] {ARMED, DIVIDE, CHECK, HOLD} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [9:0] r_rx;
  logic [9:0] r_ry;
  logic [2:0] r_col;
  logic [2:0] r_row;
  logic       r_vsync_d;
  logic       r_seen_rise;
  logic       r_kill_valid;
  logic [1:0] r_kill_row;
  logic [2:0] r_kill_col;
  logic       r_hit_alien;
  logic [7:0] r_score;
  logic [1:0] r_lives;
  logic       r_game_over;
  logic       r_wave_clear;

  logic                            w_overlap;
  logic                            w_vs_rise;
  logic                            w_vs_fall;
  logic                            w_step_x;
  logic                            w_step_y;
  logic [4:0]                      w_idx;
  logic [NUM_ROWS*NUM_COLUMNS-1:0] w_alive_shift;
  logic                            w_cell_ok;
  logic                            w_commit;
  logic [7:0]                      w_score_inc;
  logic [1:0]                      w_lives_nxt;

  assign w_overlap = display_on & laser_gfx & alien_pixel;
  assign w_vs_rise = vsync & ~r_vsync_d;
  assign w_vs_fall = ~vsync & r_vsync_d;

  // Counters saturate at the formation size, so wrapped negative offsets land out of range.
  assign w_step_x = (r_rx >= LP_CW) && (r_col < LP_COLS);
  assign w_step_y = (r_ry >= LP_CH) && (r_row < LP_ROWS);

  assign w_idx         = 5'(r_row) * LP_COLS5 + 5'(r_col);
  assign w_alive_shift = alive_matrix >> w_idx;
  assign w_cell_ok     = (r_col < LP_COLS) && (r_row < LP_ROWS) && w_alive_shift[0];

  assign w_score_inc = (r_score == 8'h99)      ? 8'h99 :
                       (r_score[3:0] == 4'd9)  ? {r_score[7:4] + 4'd1, 4'd0} :
                                                 {r_score[7:4], r_score[3:0] + 4'd1};

  assign w_lives_nxt = (bomb_hit && (r_lives != 2'd0)) ? r_lives - 2'd1 : r_lives;

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    case (r_state)
      ARMED:  if (w_overlap) w_state_nxt = DIVIDE;
      DIVIDE: if (!w_step_x && !w_step_y) w_state_nxt = CHECK;
      CHECK: begin
        if (w_cell_ok) begin
          w_commit    = 1'b1;
          w_state_nxt = HOLD;
        end else begin
          w_state_nxt = ARMED;
        end
      end
      HOLD:   if (r_seen_rise && w_vs_fall) w_state_nxt = ARMED;
      default: w_state_nxt = ARMED;
    endcase
    // Game over aborts any decode in flight; a kill already committed still finishes its hold.
    if (r_game_over && (r_state != HOLD)) begin
      w_state_nxt = ARMED;
      w_commit    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ARMED;
      r_rx         <= 10'd0;
      r_ry         <= 10'd0;
      r_col        <= 3'd0;
      r_row        <= 3'd0;
      r_vsync_d    <= 1'b0;
      r_seen_rise  <= 1'b0;
      r_kill_valid <= 1'b0;
      r_kill_row   <= 2'd0;
      r_kill_col   <= 3'd0;
      r_hit_alien  <= 1'b0;
      r_score      <= 8'h00;
      r_lives      <= LP_LIVES;
      r_game_over  <= 1'b0;
      r_wave_clear <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_vsync_d    <= vsync;
      r_wave_clear <= (alive_matrix == '0);
      r_lives      <= w_lives_nxt;
      r_game_over  <= (w_lives_nxt == 2'd0);
      r_kill_valid <= w_commit;

      if ((r_state == ARMED) && (w_state_nxt == DIVIDE)) begin
        r_rx  <= hpos - formation_x;
        r_ry  <= vpos - formation_y;
        r_col <= 3'd0;
        r_row <= 3'd0;
      end else if (r_state == DIVIDE) begin
        if (w_step_x) begin
          r_rx  <= r_rx - LP_CW;
          r_col <= r_col + 3'd1;
        end
        if (w_step_y) begin
          r_ry  <= r_ry - LP_CH;
          r_row <= r_row + 3'd1;
        end
      end

      if (w_commit) begin
        r_kill_row  <= r_row[1:0];
        r_kill_col  <= r_col;
        r_hit_alien <= 1'b1;
        r_score     <= w_score_inc;
        r_seen_rise <= 1'b0;
      end else if (r_state == HOLD) begin
        if (w_vs_rise) r_seen_rise <= 1'b1;
        if (r_seen_rise && w_vs_fall) begin
          r_hit_alien <= 1'b0;
          r_seen_rise <= 1'b0;
        end
      end
    end
  end

  assign kill_valid = r_kill_valid;
  assign kill_row   = r_kill_row;
  assign kill_col   = r_kill_col;
  assign hit_alien  = r_hit_alien;
  assign score      = r_score;
  assign lives      = r_lives;
  assign game_over  = r_game_over;
  assign wave_clear = r_wave_clear;

endmodule
